div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_if.sv | 37 +++
 rtl/div_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/div_if.sv
// ---------------------------------------------------------------------------
// div_if -- request/response bundle between the EX stage and div_unit.
//
// Signals:
//   start      : request pulse; operands and op are sampled when accepted
//   flush      : pipeline flush; aborts any operation in flight
//   div_op     : 00=DIV, 01=DIVU, 10=REM, 11=REMU
//   data1      : dividend (rs1)
//   data2      : divisor (rs2)
//   busy       : high while an operation is in flight (stall request)
//   done       : one-cycle pulse, div_result valid
//   div_result : quotient or remainder of the captured op
//
// Modports: master (pipeline side), slave (divider side).
// ---------------------------------------------------------------------------
interface div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [1:0]      div_op;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] div_result;

  modport master (
    output start, flush, div_op, data1, data2,
    input  busy, done, div_result
  );

  modport slave (
    input  start, flush, div_op, data1, data2,
    output busy, done, div_result
  );
endinterface

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//
// Ports:
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : div_if.slave (start/flush/div_op/data1/data2 in,
//             busy/done/div_result out)
//
// A request accepted at edge N keeps busy high for 32 cycles (one iteration
// per edge on the operand magnitudes), then done pulses for one cycle with the
// signed-corrected result. div_result holds until the next accepted request.
//
// Configuration macro:
//   DIV_EARLY_OUT_EN : when defined, divide-by-zero and signed-overflow
//                      requests skip the iterations and finish after a single
//                      busy cycle. Results are identical either way.
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  div_if.slave  io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_dividend;
  logic [XLEN-1:0] r_divisorMag;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic            r_negQ;
  logic            r_negR;
  logic            r_divZero;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // Capture-side decode: DIV and REM (op[0]=0) are the signed flavours.
  logic            w_isSigned;
  logic            w_aNeg;
  logic            w_bNeg;
  logic [XLEN-1:0] w_aMag;
  logic [XLEN-1:0] w_bMag;
  logic            w_divZero;
  logic            w_ovf;

  assign w_isSigned = ~io_bus.div_op[0];
  assign w_aNeg     = w_isSigned & io_bus.data1[XLEN-1];
  assign w_bNeg     = w_isSigned & io_bus.data2[XLEN-1];
  assign w_aMag     = w_aNeg ? (~io_bus.data1 + 1'b1) : io_bus.data1;
  assign w_bMag     = w_bNeg ? (~io_bus.data2 + 1'b1) : io_bus.data2;
  assign w_divZero  = (io_bus.data2 == '0);
  assign w_ovf      = w_isSigned & (io_bus.data1 == MIN_NEG) & (io_bus.data2 == ALL_ONES);

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. r_quo starts as the
  // dividend magnitude and is shifted out MSB-first while quotient bits
  // shift in at the bottom.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_fits;
  logic [XLEN-1:0] w_nextRem;
  logic [XLEN-1:0] w_nextQuo;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_diff    = w_shift - {1'b0, r_divisorMag};
  assign w_fits    = ~w_diff[XLEN];
  assign w_nextRem = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_nextQuo = {r_quo[XLEN-2:0], w_fits};

  // Divide-by-zero and overflow are resolved from the captured flags so the
  // signed quotient of x/0 is all ones rather than a sign-corrected value.
  logic [XLEN-1:0] w_special;
  logic [XLEN-1:0] w_quoSigned;
  logic [XLEN-1:0] w_remSigned;
  logic [XLEN-1:0] w_finalResult;
  logic            w_earlyOut;

  assign w_special     = r_op[1] ? (r_divZero ? r_dividend : '0)
                                 : (r_divZero ? ALL_ONES : MIN_NEG);
  assign w_quoSigned   = r_negQ ? (~w_nextQuo + 1'b1) : w_nextQuo;
  assign w_remSigned   = r_negR ? (~w_nextRem + 1'b1) : w_nextRem;
  assign w_finalResult = (r_divZero | r_ovf) ? w_special
                                             : (r_op[1] ? w_remSigned : w_quoSigned);

`ifdef DIV_EARLY_OUT_EN
  assign w_earlyOut = r_divZero | r_ovf;
`else
  assign w_earlyOut = 1'b0;
`endif

  // Control FSM plus datapath registers. busy/done are registered alongside
  // the state so they are glitch-free for the hazard unit. Flush beats start
  // in every state and never touches the result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op         <= '0;
      r_dividend   <= '0;
      r_divisorMag <= '0;
      r_quo        <= '0;
      r_rem        <= '0;
      r_negQ       <= 1'b0;
      r_negR       <= 1'b0;
      r_divZero    <= 1'b0;
      r_ovf        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (io_bus.start && !io_bus.flush) begin
            r_state      <= S_BUSY;
            r_busy       <= 1'b1;
            r_cnt        <= '0;
            r_op         <= io_bus.div_op;
            r_dividend   <= io_bus.data1;
            r_divisorMag <= w_bMag;
            r_quo        <= w_aMag;
            r_rem        <= '0;
            r_negQ       <= w_aNeg ^ w_bNeg;
            r_negR       <= w_aNeg;
            r_divZero    <= w_divZero;
            r_ovf        <= w_ovf;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_BUSY: begin
          if (io_bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (w_earlyOut) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_special;
          end else begin
            r_quo <= w_nextQuo;
            r_rem <= w_nextRem;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_finalResult;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.div_result = r_result;

endmodule
